prefetch_queue: RTL and testbench

Producer end of the decoder's PQ interface (rqi/nxi/cmd). Fetches 16-bit words from the memory bus, assembles big-endian 32-bit instruction words and buffers them in a small FIFO. Presents the head entry to the decoder and supports a flush/redirect for taken branches.

---
 rtl/prefetch_queue_pkg.sv | 27 ++
 rtl/prefetch_queue_if.sv | 29 ++
 rtl/prefetch_queue_fifo.sv | 63 ++++++
 rtl/prefetch_queue.sv | 151 +++++++++++++++
 tb/tb_prefetch_queue.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prefetch_queue_pkg.sv
// Shared types for the prefetch queue: bus FSM states, field widths, entry layout.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package prefetch_queue_pkg;

    localparam int PQ_CMD_W  = 32;
    localparam int PQ_ADR_W  = 16;
    localparam int PQ_HALF_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_FETCH_HI = 2'b01,
        ST_FETCH_LO = 2'b10
    } pq_state_e;

    // One buffered instruction: its word address and the big-endian pair.
    typedef struct packed {
        logic [PQ_ADR_W-1:0] ipc;
        logic [PQ_CMD_W-1:0] cmd;
    } pq_entry_t;

    // Word address increment; 16'hFFFF wraps to 16'h0000.
    function automatic logic [PQ_ADR_W-1:0] adr_inc(input logic [PQ_ADR_W-1:0] a);
        return a + PQ_ADR_W'(1);
    endfunction

endpackage

// File: rtl/prefetch_queue_if.sv
// Decoder (rqi/nxi/cmd/ipc/flush) and memory-bus (req/adr/ack/din) signals of the prefetch queue.
// Latency: n/a (wires only).
// Backpressure: rqi pops only when nxi is high; bus req is held until ack.
// Ports: master = prefetch queue side, slave = decoder plus memory side.
interface prefetch_queue_if;
    import prefetch_queue_pkg::*;

    logic                 rqi;
    logic                 nxi;
    logic [PQ_CMD_W-1:0]  cmd;
    logic [PQ_ADR_W-1:0]  ipc;
    logic                 flush;
    logic [PQ_ADR_W-1:0]  flush_adr;
    logic                 req;
    logic [PQ_ADR_W-1:0]  adr;
    logic                 ack;
    logic [PQ_HALF_W-1:0] din;

    modport master (
        input  rqi, flush, flush_adr, ack, din,
        output nxi, cmd, ipc, req, adr
    );

    modport slave (
        output rqi, flush, flush_adr, ack, din,
        input  nxi, cmd, ipc, req, adr
    );

endinterface

// File: rtl/prefetch_queue_fifo.sv
// Synchronous FIFO of pq_entry_t with push, pop and clear.
// Latency: a push is visible at the head on the cycle after the push edge.
// Backpressure: none internal; the caller must not push when full or pop when empty.
// Ports: clk, rst_n, push/push_dat, pop, clear -> head_dat, empty, count.
module pq_fifo
    import prefetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  pq_entry_t              push_dat,
    input  logic                   pop,
    input  logic                   clear,
    output pq_entry_t              head_dat,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    pq_entry_t   mem_q [DEPTH];
    pq_entry_t   mem_d [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q[AW-1:0]] = push_dat;
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

    assign count    = wr_ptr_q - rd_ptr_q;
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign head_dat = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/prefetch_queue.sv
// Prefetch queue: fetches 16-bit words, packs big-endian 32-bit instructions, buffers DEPTH of them.
// Latency: zero-wait bus -> nxi rises the cycle after the second (low-half) ack.
// Backpressure: fetch idles while buffered + in-assembly instructions fill DEPTH; req/adr hold until ack.
// Ports: clk, rst_n, pq (master modport: decoder rqi/nxi/cmd/ipc/flush/flush_adr, bus req/adr/ack/din).
module prefetch_queue
    import prefetch_queue_pkg::*;
#(
    parameter int                  DEPTH    = 4,
    parameter logic [PQ_ADR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic             clk,
    input  logic             rst_n,
    prefetch_queue_if.master pq
);

    localparam int CW = $clog2(DEPTH) + 1;

    pq_state_e              state_q,  state_d;
    logic                   req_q,    req_d;
    logic [PQ_ADR_W-1:0]    adr_q,    adr_d;     // current fetch / bus address
    logic [PQ_ADR_W-1:0]    redir_q,  redir_d;   // flush target while a stale bus cycle drains
    logic [PQ_ADR_W-1:0]    hi_adr_q, hi_adr_d;  // address of the instruction being assembled
    logic [PQ_HALF_W-1:0]   hi_q,     hi_d;
    logic                   drop_q,   drop_d;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_empty;
    logic [CW-1:0]          fifo_count;
    pq_entry_t              push_entry;
    pq_entry_t              head_entry;
    logic                   bus_done;
    logic                   room_now;
    logic                   room_after_push;

    assign bus_done        = req_q & pq.ack;
    // IDLE has nothing in assembly, so only buffered entries count.
    assign room_now        = fifo_count < CW'(DEPTH);
    // At the low-half ack the pushed entry now occupies a slot; a same-cycle pop is not credited.
    assign room_after_push = fifo_count < CW'(DEPTH - 1);
    assign push_entry      = '{ipc: hi_adr_q, cmd: {hi_q, pq.din}};
    assign fifo_pop        = pq.rqi & ~fifo_empty & ~pq.flush;

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        adr_d     = adr_q;
        redir_d   = redir_q;
        hi_adr_d  = hi_adr_q;
        hi_d      = hi_q;
        drop_d    = drop_q;
        fifo_push = 1'b0;

        if (pq.flush) begin
            if (req_q && !pq.ack) begin
                // Bus cycle in flight: it cannot be withdrawn, so let it finish and discard its data.
                drop_d  = 1'b1;
                redir_d = pq.flush_adr;
            end else begin
                // Bus idle or completing now: restart immediately at the target.
                drop_d  = 1'b0;
                adr_d   = pq.flush_adr;
                redir_d = pq.flush_adr;
                state_d = ST_FETCH_HI;
                req_d   = 1'b1;
            end
        end else if (drop_q) begin
            if (bus_done) begin
                drop_d  = 1'b0;
                adr_d   = redir_q;
                state_d = ST_FETCH_HI;
                req_d   = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (room_now) begin
                        state_d = ST_FETCH_HI;
                        req_d   = 1'b1;
                    end
                end
                ST_FETCH_HI: begin
                    if (bus_done) begin
                        hi_d     = pq.din;
                        hi_adr_d = adr_q;
                        adr_d    = adr_inc(adr_q);
                        state_d  = ST_FETCH_LO;
                    end
                end
                ST_FETCH_LO: begin
                    if (bus_done) begin
                        fifo_push = 1'b1;
                        adr_d     = adr_inc(adr_q);
                        if (room_after_push) begin
                            state_d = ST_FETCH_HI;
                        end else begin
                            state_d = ST_IDLE;
                            req_d   = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            req_q    <= 1'b0;
            adr_q    <= RESET_PC;
            redir_q  <= RESET_PC;
            hi_adr_q <= RESET_PC;
            hi_q     <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            adr_q    <= adr_d;
            redir_q  <= redir_d;
            hi_adr_q <= hi_adr_d;
            hi_q     <= hi_d;
            drop_q   <= drop_d;
        end
    end

    pq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_dat (push_entry),
        .pop      (fifo_pop),
        .clear    (pq.flush),
        .head_dat (head_entry),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign pq.req = req_q;
    assign pq.adr = adr_q;
    assign pq.nxi = ~fifo_empty;
    assign pq.cmd = fifo_empty ? '0 : head_entry.cmd;
    // With nothing buffered, report where fetching will resume.
    assign pq.ipc = fifo_empty ? (drop_q ? redir_q : adr_q) : head_entry.ipc;

endmodule

// File: tb/tb_prefetch_queue.sv
module tb_prefetch_queue;

    logic clk = 1'b0;
    logic rst_n;
    logic rst2_n;

    always #5 clk = ~clk;

    prefetch_queue_if pq ();
    prefetch_queue_if pq2 ();

    prefetch_queue #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pq    (pq)
    );

    prefetch_queue #(.DEPTH(4), .RESET_PC(16'hFFFF)) dut_wrap (
        .clk   (clk),
        .rst_n (rst2_n),
        .pq    (pq2)
    );

    int n_chk = 0;
    int n_err = 0;

    // Memory model for dut: returns din = adr after bus_wait idle cycles of req.
    logic bus_en;
    int   bus_wait;
    int   wcnt;

    initial begin
        pq.ack = 1'b0;
        pq.din = '0;
        wcnt   = 0;
        forever begin
            @(negedge clk);
            if (pq.ack) begin
                pq.ack = 1'b0;
                wcnt   = 0;
            end
            if (!pq.req) begin
                wcnt = 0;
            end else if (bus_en) begin
                if (wcnt >= bus_wait) begin
                    pq.ack = 1'b1;
                    pq.din = pq.adr;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    // Zero-wait memory model for dut_wrap.
    initial begin
        pq2.ack = 1'b0;
        pq2.din = '0;
        forever begin
            @(negedge clk);
            pq2.ack = pq2.req;
            pq2.din = pq2.adr;
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_err++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    task automatic do_reset(input int w);
        pq.rqi       = 1'b0;
        pq.flush     = 1'b0;
        pq.flush_adr = '0;
        bus_en       = 1'b1;
        bus_wait     = w;
        rst_n        = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        rqi;
        logic        flush;
        logic [15:0] fadr;
        logic        bus_en;
        logic        nxi;
        logic [31:0] cmd;
        logic [15:0] ipc;
        logic        req;
        logic [15:0] adr;
    } vec_t;

    function automatic vec_t mk(input logic rqi, input logic en, input logic nxi,
                                input logic [31:0] cmd, input logic [15:0] ipc,
                                input logic req, input logic [15:0] adr);
        vec_t v;
        v.rqi    = rqi;
        v.flush  = 1'b0;
        v.fadr   = 16'h0000;
        v.bus_en = en;
        v.nxi    = nxi;
        v.cmd    = cmd;
        v.ipc    = ipc;
        v.req    = req;
        v.adr    = adr;
        return v;
    endfunction

    localparam int NV = 22;
    vec_t vecs [NV];
    bit   found;

    initial begin
        // Row k: inputs sampled at the k-th posedge after reset release, outputs expected after it.
        // bus_en takes effect at the responder's next negedge.
        vecs[0]  = mk(0, 1, 0, 32'h0000_0000, 16'h0000, 1, 16'h0000);
        vecs[1]  = mk(0, 1, 0, 32'h0000_0000, 16'h0001, 1, 16'h0001);
        vecs[2]  = mk(0, 1, 1, 32'h0000_0001, 16'h0000, 1, 16'h0002);
        vecs[3]  = mk(0, 1, 1, 32'h0000_0001, 16'h0000, 1, 16'h0003);
        vecs[4]  = mk(0, 1, 1, 32'h0000_0001, 16'h0000, 1, 16'h0004);
        vecs[5]  = mk(0, 1, 1, 32'h0000_0001, 16'h0000, 1, 16'h0005);
        vecs[6]  = mk(0, 1, 1, 32'h0000_0001, 16'h0000, 1, 16'h0006);
        vecs[7]  = mk(0, 1, 1, 32'h0000_0001, 16'h0000, 1, 16'h0007);
        vecs[8]  = mk(0, 1, 1, 32'h0000_0001, 16'h0000, 0, 16'h0008);
        vecs[9]  = mk(0, 1, 1, 32'h0000_0001, 16'h0000, 0, 16'h0008);
        vecs[10] = mk(1, 1, 1, 32'h0002_0003, 16'h0002, 0, 16'h0008);
        vecs[11] = mk(0, 1, 1, 32'h0002_0003, 16'h0002, 1, 16'h0008);
        vecs[12] = mk(0, 1, 1, 32'h0002_0003, 16'h0002, 1, 16'h0009);
        vecs[13] = mk(0, 1, 1, 32'h0002_0003, 16'h0002, 0, 16'h000A);
        vecs[14] = mk(1, 0, 1, 32'h0004_0005, 16'h0004, 0, 16'h000A);
        vecs[15] = mk(1, 0, 1, 32'h0006_0007, 16'h0006, 1, 16'h000A);
        vecs[16] = mk(1, 0, 1, 32'h0008_0009, 16'h0008, 1, 16'h000A);
        vecs[17] = mk(1, 0, 0, 32'h0000_0000, 16'h000A, 1, 16'h000A);
        vecs[18] = mk(1, 0, 0, 32'h0000_0000, 16'h000A, 1, 16'h000A);
        vecs[19] = mk(0, 1, 0, 32'h0000_0000, 16'h000A, 1, 16'h000A);
        vecs[20] = mk(0, 1, 0, 32'h0000_0000, 16'h000B, 1, 16'h000B);
        vecs[21] = mk(0, 1, 1, 32'h000A_000B, 16'h000A, 1, 16'h000C);

        rst_n        = 1'b0;
        rst2_n       = 1'b0;
        pq.rqi       = 1'b0;
        pq.flush     = 1'b0;
        pq.flush_adr = '0;
        pq2.rqi      = 1'b0;
        pq2.flush    = 1'b0;
        pq2.flush_adr = '0;
        bus_en       = 1'b1;
        bus_wait     = 0;
        tick();
        tick();

        check("reset.nxi", {31'd0, pq.nxi}, 32'd0);
        check("reset.cmd", pq.cmd, 32'd0);
        check("reset.ipc", {16'd0, pq.ipc}, 32'h0000);
        check("reset.req", {31'd0, pq.req}, 32'd0);
        check("reset.adr", {16'd0, pq.adr}, 32'h0000);

        // Fill to full, pop at full, drain through empty, rqi while empty, refill.
        rst_n = 1'b1;
        for (int i = 0; i < NV; i++) begin
            pq.rqi       = vecs[i].rqi;
            pq.flush     = vecs[i].flush;
            pq.flush_adr = vecs[i].fadr;
            bus_en       = vecs[i].bus_en;
            tick();
            check($sformatf("vec%0d.nxi", i), {31'd0, pq.nxi}, {31'd0, vecs[i].nxi});
            check($sformatf("vec%0d.cmd", i), pq.cmd, vecs[i].cmd);
            check($sformatf("vec%0d.ipc", i), {16'd0, pq.ipc}, {16'd0, vecs[i].ipc});
            check($sformatf("vec%0d.req", i), {31'd0, pq.req}, {31'd0, vecs[i].req});
            check($sformatf("vec%0d.adr", i), {16'd0, pq.adr}, {16'd0, vecs[i].adr});
        end
        pq.rqi = 1'b0;

        // Flush during FETCH_LO with a 3-cycle bus wait: stale cycle drains, then redirect.
        do_reset(3);
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (pq.req && pq.adr == 16'h0001) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) timeout("drop.reach_lo");
        pq.flush     = 1'b1;
        pq.flush_adr = 16'h0200;
        tick();
        check("drop.req_held", {31'd0, pq.req}, 32'd1);
        check("drop.adr_held0", {16'd0, pq.adr}, 32'h0001);
        check("drop.nxi", {31'd0, pq.nxi}, 32'd0);
        // Second flush while draining only retargets.
        pq.flush_adr = 16'h0100;
        tick();
        pq.flush = 1'b0;
        check("drop.adr_held1", {16'd0, pq.adr}, 32'h0001);
        tick();
        check("drop.adr_held2", {16'd0, pq.adr}, 32'h0001);
        tick();
        check("drop.redir_adr", {16'd0, pq.adr}, 32'h0100);
        check("drop.redir_req", {31'd0, pq.req}, 32'd1);
        found = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (pq.nxi) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) timeout("drop.first_cmd");
        check("drop.cmd", pq.cmd, 32'h0100_0101);
        check("drop.ipc", {16'd0, pq.ipc}, 32'h0100);

        // Flush coincident with ack and rqi.
        do_reset(0);
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (pq.nxi) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) timeout("coin.fill");
        pq.flush     = 1'b1;
        pq.flush_adr = 16'h0300;
        pq.rqi       = 1'b1;
        tick();
        pq.flush = 1'b0;
        pq.rqi   = 1'b0;
        check("coin.nxi", {31'd0, pq.nxi}, 32'd0);
        check("coin.cmd", pq.cmd, 32'd0);
        check("coin.ipc", {16'd0, pq.ipc}, 32'h0300);
        check("coin.req", {31'd0, pq.req}, 32'd1);
        check("coin.adr", {16'd0, pq.adr}, 32'h0300);
        tick();
        check("coin.adr_lo", {16'd0, pq.adr}, 32'h0301);
        tick();
        check("coin.nxi2", {31'd0, pq.nxi}, 32'd1);
        check("coin.cmd2", pq.cmd, 32'h0300_0301);
        check("coin.ipc2", {16'd0, pq.ipc}, 32'h0300);

        // Address wrap from RESET_PC = 16'hFFFF, then asynchronous reset mid-fetch.
        rst2_n = 1'b1;
        tick();
        check("wrap.adr0", {16'd0, pq2.adr}, 32'hFFFF);
        check("wrap.req0", {31'd0, pq2.req}, 32'd1);
        tick();
        check("wrap.adr1", {16'd0, pq2.adr}, 32'h0000);
        tick();
        check("wrap.nxi", {31'd0, pq2.nxi}, 32'd1);
        check("wrap.cmd", pq2.cmd, 32'hFFFF_0000);
        check("wrap.ipc", {16'd0, pq2.ipc}, 32'hFFFF);
        check("wrap.adr2", {16'd0, pq2.adr}, 32'h0001);
        tick();
        rst2_n = 1'b0;
        #1;
        check("arst.req", {31'd0, pq2.req}, 32'd0);
        check("arst.nxi", {31'd0, pq2.nxi}, 32'd0);
        check("arst.cmd", pq2.cmd, 32'd0);
        check("arst.adr", {16'd0, pq2.adr}, 32'hFFFF);
        check("arst.ipc", {16'd0, pq2.ipc}, 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
